// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined imem requests and buffers {pc, ins} for ID.
// Optional FETCH_QUEUE_BYPASS_EN lets a response reach ID combinationally when the FIFO is empty.
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [31:0]              if_ins,
  output logic [XLEN-1:0]          if_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop;

  logic            fifo_empty;
  logic            grant;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            bypass_ok;
  logic            bypass_take;
  logic [SW-1:0]   credit_used;
  logic [XLEN-1:0] resp_pc;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign fifo_empty  = (count == '0);
  assign credit_used = SW'(count) + SW'(outstanding);
  // Credit counts in-flight requests against free FIFO slots, so responses never need back-pressure.
  assign imem_req    = rst & ~redirect_valid & (credit_used < SW'(DEPTH))
                     & (outstanding < OW'(MAX_OUTSTANDING));
  assign imem_addr   = pc;
  assign grant       = imem_req & imem_gnt;
  // A response with nothing outstanding belongs to an abandoned request and is ignored.
  assign rsp         = imem_rvalid & (outstanding != '0);

  // Responses return in order and pc advances by 4 per grant, so the oldest live request sits
  // outstanding words behind pc (dropped ones only exist while drop > 0, when no push happens).
  assign resp_pc = pc - (XLEN'(outstanding) << 2);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_ok = fifo_empty & ~redirect_valid & (drop == '0) & rsp;
`else
  assign bypass_ok = 1'b0;
`endif

  assign bypass_take = bypass_ok & if_ready;
  assign pop         = ~fifo_empty & if_ready;
  assign push        = rsp & (drop == '0) & ~redirect_valid & ~bypass_take;

  assign if_valid = rst & (~fifo_empty | bypass_ok);
  assign q_count  = count;

  always_comb begin
    if_ins = NOP;
    if_pc  = pc_mem[rd_ptr];
    if (~fifo_empty) begin
      if_ins = ins_mem[rd_ptr];
    end else if (bypass_ok) begin
      if_ins = imem_rdata;
      if_pc  = resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight is stale; a response landing now is discarded immediately.
      pc          <= {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - OW'(rsp);
      drop        <= outstanding - OW'(rsp);
    end else begin
      if (grant) begin
        pc <= pc + XLEN'(4);
      end
      outstanding <= outstanding + OW'(grant) - OW'(rsp);
      if (rsp && (drop != '0)) begin
        drop <= drop - OW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= resp_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: imem model with variable latency, reference fetch-PC tracker and an
// expected-output queue checked by an independent monitor.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int FIRST_LAT  = 1;
  localparam int STEADY_CNT = 0;
`else
  localparam int FIRST_LAT  = 2;
  localparam int STEADY_CNT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [2:0]  q_count;

  int n_err = 0;
  int n_checks = 0;
  int n_pop = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] exp_pc = RESET_PC;
  bit clr_next = 1'b0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_ins(if_ins), .if_pc(if_pc),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // imem: grants seen mid-cycle, responses returned lat cycles later in order.
  initial begin : imem_model
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pend_addr.delete();
        pend_due.delete();
        exp_pc_q.delete();
        exp_ins_q.delete();
        exp_pc = RESET_PC;
        clr_next = 1'b0;
        imem_rvalid = 1'b0;
      end else begin
        if (clr_next) begin
          exp_pc_q.delete();
          exp_ins_q.delete();
          clr_next = 1'b0;
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
        end
      end
      @(negedge clk);
      if (rst) begin
        if (imem_req && imem_gnt) begin
          check("grant_addr", imem_addr, exp_pc);
          pend_addr.push_back(imem_addr);
          pend_due.push_back(cyc + lat);
          exp_pc_q.push_back(exp_pc);
          exp_ins_q.push_back(mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
          exp_pc = {redirect_pc[31:2], 2'b00};
          clr_next = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (if_valid && if_ready) begin
          if (exp_pc_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_output: got pc %h ins %h, nothing expected", if_pc, if_ins);
          end else begin
            e_pc  = exp_pc_q.pop_front();
            e_ins = exp_ins_q.pop_front();
            check("out_pc", if_pc, e_pc);
            check("out_ins", if_ins, e_ins);
          end
          n_pop++;
          last_pc = if_pc;
        end
        if (!if_valid) check("idle_nop", if_ins, NOP);
        if (q_count == 3'd4) check("full_no_req", 32'(imem_req), 32'd0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    @(negedge clk);
    while (!if_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain_expected_left", 32'(exp_pc_q.size()), 32'd0);
    check("drain_q_count", 32'(q_count), 32'd0);
  endtask

  initial begin : watchdog
    #50000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int n0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_ins", if_ins, NOP);

    // 1: streaming, gnt=1, L=1, ready=1
    imem_gnt = 1'b1; if_ready = 1'b1; lat = 1;
    do_reset();
    wait_valid(10, n);
    check("t1_first_latency", 32'(n), 32'(FIRST_LAT));
    check("t1_first_pc", if_pc, 32'h0);
    #1 n0 = n_pop;
    repeat (8) @(negedge clk);
    #1 check("t1_throughput", 32'(n_pop - n0), 32'd8);
    drain();

    // 2: ID stalled from reset, FIFO fills
    imem_gnt = 1'b1; if_ready = 1'b0; lat = 1;
    do_reset();
    cycles(8);
    @(negedge clk);
    check("t2_q_full", 32'(q_count), 32'd4);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(if_valid), 32'd1);
    check("t2_head_pc", if_pc, 32'h0);
    check("t2_head_ins", if_ins, mem_word(32'h0));
    cycles(1);
    if_ready = 1'b1;
    cycles(1);
    @(negedge clk);
    check("t2_resume_req", 32'(imem_req), 32'd1);
    check("t2_resume_addr", imem_addr, 32'h10);
    cycles(6);
    drain();

    // 3: two outstanding with L=3, redirect to 0x100
    imem_gnt = 1'b1; if_ready = 1'b1; lat = 3;
    do_reset();
    cycles(2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("t3_no_req_redirect", 32'(imem_req), 32'd0);
    cycles(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_q_empty", 32'(q_count), 32'd0);
    check("t3_no_valid", 32'(if_valid), 32'd0);
    wait_valid(20, n);
    check("t3_first_pc", if_pc, 32'h100);
    check("t3_first_ins", if_ins, mem_word(32'h100));
    cycles(4);
    drain();

    // 4: redirect to 0x103 with coincident response and pop
    imem_gnt = 1'b1; if_ready = 1'b1; lat = 1;
    do_reset();
    cycles(4);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    check("t4_pop_valid", 32'(if_valid), 32'(STEADY_CNT));
    check("t4_q_before", 32'(q_count), 32'(STEADY_CNT));
    cycles(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_q_after", 32'(q_count), 32'd0);
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h100);
    check("t4_no_valid", 32'(if_valid), 32'd0);
    wait_valid(10, n);
    check("t4_first_pc", if_pc, 32'h100);

    // 5: PC wrap through redirect to FFFF_FFF8
    cycles(4);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycles(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_addr0", imem_addr, 32'hFFFF_FFF8);
    #1 n0 = n_pop;
    for (int i = 0; i < 20 && n_pop < n0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("t5_three_pops", 32'(n_pop - n0), 32'd3);
    check("t5_wrapped_pc", last_pc, 32'h0);
    drain();

    // 6: grant withheld, then reset mid-burst
    imem_gnt = 1'b0; if_ready = 1'b1; lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_stall_req", 32'(imem_req), 32'd1);
      check("t6_stall_addr", imem_addr, 32'h0);
      check("t6_stall_q", 32'(q_count), 32'd0);
      cycles(1);
    end
    imem_gnt = 1'b1; if_ready = 1'b0;
    cycles(6);
    @(negedge clk);
    check("t6_q_full", 32'(q_count), 32'd4);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(if_valid), 32'd0);
    check("t6_rst_q", 32'(q_count), 32'd0);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    if_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    wait_valid(10, n);
    check("t6_restart_pc", if_pc, 32'h0);
    cycles(5);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
